key_decoder: RTL
================

KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000, the number of consecutive stable cycles required to accept a press or a release.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port key_in, input, 6 bits: raw asynchronous one-hot keypad lines.
  - [5] coin 100, [4] coin 50, [3] candy out, [2] cancel, [1] coin 10, [0] unassigned.
REQ-005 SHALL have port coin, output, 2 bits: coin code; 01=10, 10=50, 11=100, 00 when not valid.
REQ-006 SHALL have port coin_valid, output, 1 bit: one-cycle pulse qualifying coin.
REQ-007 SHALL have port btn, output, 2 bits: button code; 01=candy, 10=cancel, 00 when not valid.
REQ-008 SHALL have port btn_valid, output, 1 bit: one-cycle pulse qualifying btn.
REQ-009 SHALL have port key_err, output, 1 bit: one-cycle pulse on acceptance of an invalid key pattern.

Function
REQ-010 SHALL pass key_in through a two-flop synchronizer before any other logic uses it.
REQ-011 SHALL implement the states IDLE, PRESS_DB, HELD and REL_DB.
REQ-012 IDLE: a nonzero synchronized key SHALL latch the key pattern, load the counter with 0 and go to PRESS_DB.
REQ-013 PRESS_DB: if the synchronized key equals the latched pattern, the counter SHALL increment.
  - When the counter reaches DEBOUNCE_CYCLES-1, the state SHALL move to HELD and emit exactly one output pulse.
REQ-014 PRESS_DB: any change of the synchronized key SHALL act as follows.
  - Change to zero: return to IDLE with no pulse.
  - Change to a different nonzero pattern: relatch that pattern and clear the counter.
REQ-015 Pulse selection SHALL be decided from the latched pattern.
  - Valid one-hot coin pattern: coin_valid with the coin code.
  - Valid one-hot button pattern: btn_valid with the button code.
  - Multi-hot pattern or bit [0]: key_err only.
  - Never more than one of coin_valid, btn_valid, key_err in any cycle.
REQ-016 Latency: with key_in stable from the first capturing edge E, the pulse SHALL be high during the cycle following edge E+DEBOUNCE_CYCLES+2.
  - For the default of 1000, this is 1003 edges after E.
REQ-017 HELD: no further pulses SHALL be generated (no auto-repeat).
  - Any change of the synchronized key SHALL clear the counter and go to REL_DB.
REQ-018 REL_DB: the counter SHALL count consecutive all-zero samples.
  - At DEBOUNCE_CYCLES-1, the state SHALL go to IDLE.
  - Any nonzero sample SHALL clear the counter and stay in REL_DB.
REQ-019 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-020 coin and btn SHALL be 00 in every cycle in which their valid is low.

Reset
REQ-021 On reset, the following SHALL apply at the next clock edge:
  - synchronizer flops, latched pattern and counter cleared to 0;
  - state set to IDLE;
  - coin, coin_valid, btn, btn_valid and key_err all 0.
REQ-022 Reset SHALL take priority over all state transitions, including a pulse due in the same cycle; that pulse SHALL be suppressed.
REQ-023 A key held across reset deassertion SHALL be debounced afresh and produce exactly one pulse.

Structure
REQ-024 The key bit positions, coin codes, button codes and state encoding SHALL live in the shared package candy_pkg.
REQ-025 The two-flop synchronizer SHALL be a separate sub-module, key_sync, parameterised by width.
  - All remaining logic (FSM, counter, encoder) SHALL be in key_decoder.

Verification
REQ-026 key_in=100_000 for 2000 cycles, then 0 -> one coin_valid with coin=11, 1003 edges after the first capture; no other pulses.
REQ-027 key_in=001_000 for 2000 cycles -> one btn_valid with btn=01; coin_valid and key_err stay 0.
REQ-028 key_in toggles 100_000/0 every 50 cycles for 600 cycles, then holds 100_000 -> exactly one coin_valid, 1003 edges after the final rising transition.
REQ-029 key_in=110_000 for 2000 cycles -> one key_err pulse; coin_valid and btn_valid stay 0.
REQ-030 key_in=100_000 for 900 cycles, then 0 -> no pulse of any kind; the state returns to IDLE.
REQ-031 key_in=010_000 held, reset pulsed 500 cycles after the first capture -> no pulse before reset; one coin_valid with coin=10 after reset release, per the REQ-016 timing counted from the first capturing edge after reset release.

Source files
------------

// File: rtl/candy_pkg.sv
// Shared keypad definitions for the candy machine: key bit positions, output codes,
// decoder FSM encoding and the latched-pattern classifier.
package candy_pkg;

    localparam int KEY_W       = 6;
    localparam int KEY_COIN100 = 5;
    localparam int KEY_COIN50  = 4;
    localparam int KEY_CANDY   = 3;
    localparam int KEY_CANCEL  = 2;
    localparam int KEY_COIN10  = 1;
    localparam int KEY_UNUSED  = 0;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_10   = 2'b01;
    localparam logic [1:0] COIN_50   = 2'b10;
    localparam logic [1:0] COIN_100  = 2'b11;

    localparam logic [1:0] BTN_NONE   = 2'b00;
    localparam logic [1:0] BTN_CANDY  = 2'b01;
    localparam logic [1:0] BTN_CANCEL = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kd_state_e;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_COIN = 2'd1,
        KEY_BTN  = 2'd2,
        KEY_ERR  = 2'd3
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [1:0] code;
    } key_decode_t;

    // Anything that is not exactly one assigned key (multi-hot or bit 0) is an error.
    function automatic key_decode_t decode_key(input logic [KEY_W-1:0] k);
        key_decode_t d;
        d.cls  = KEY_ERR;
        d.code = 2'b00;
        if (k == '0) begin
            d.cls = KEY_NONE;
        end else if (k == (KEY_W'(1) << KEY_COIN100)) begin
            d.cls  = KEY_COIN;
            d.code = COIN_100;
        end else if (k == (KEY_W'(1) << KEY_COIN50)) begin
            d.cls  = KEY_COIN;
            d.code = COIN_50;
        end else if (k == (KEY_W'(1) << KEY_COIN10)) begin
            d.cls  = KEY_COIN;
            d.code = COIN_10;
        end else if (k == (KEY_W'(1) << KEY_CANDY)) begin
            d.cls  = KEY_BTN;
            d.code = BTN_CANDY;
        end else if (k == (KEY_W'(1) << KEY_CANCEL)) begin
            d.cls  = KEY_BTN;
            d.code = BTN_CANCEL;
        end
        return d;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad lines into the clk domain.
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/key_decoder.sv
// Keypad decoder: debounces press and release of the synchronized key lines and emits
// a single registered coin / button / error pulse per accepted press.
module key_decoder
    import candy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_in,
    output logic [1:0]       coin,
    output logic             coin_valid,
    output logic [1:0]       btn,
    output logic             btn_valid,
    output logic             key_err
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic [KEY_W-1:0] key_s;
    kd_state_e        state_q, state_d;
    logic [KEY_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       coin_q, coin_d;
    logic             coin_vld_q, coin_vld_d;
    logic [1:0]       btn_q, btn_d;
    logic             btn_vld_q, btn_vld_d;
    logic             err_q, err_d;
    key_decode_t      dec;

    key_sync #(.WIDTH(KEY_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_in),
        .q_o   (key_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            cnt_q      <= '0;
            coin_q     <= COIN_NONE;
            coin_vld_q <= 1'b0;
            btn_q      <= BTN_NONE;
            btn_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            coin_q     <= coin_d;
            coin_vld_q <= coin_vld_d;
            btn_q      <= btn_d;
            btn_vld_q  <= btn_vld_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        coin_d     = COIN_NONE;
        coin_vld_d = 1'b0;
        btn_d      = BTN_NONE;
        btn_vld_d  = 1'b0;
        err_d      = 1'b0;
        dec        = decode_key(pat_q);

        case (state_q)
            IDLE: begin
                if (key_s != '0) begin
                    pat_d   = key_s;
                    cnt_d   = '0;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (key_s == pat_q) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = HELD;
                        // The single pulse for this press is decided here and nowhere else.
                        case (dec.cls)
                            KEY_COIN: begin
                                coin_vld_d = 1'b1;
                                coin_d     = dec.code;
                            end
                            KEY_BTN: begin
                                btn_vld_d = 1'b1;
                                btn_d     = dec.code;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else if (key_s == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    pat_d = key_s;
                    cnt_d = '0;
                end
            end
            HELD: begin
                if (key_s != pat_q) begin
                    cnt_d   = '0;
                    state_d = REL_DB;
                end
            end
            REL_DB: begin
                if (key_s == '0) begin
                    if (cnt_q >= CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign coin       = coin_q;
    assign coin_valid = coin_vld_q;
    assign btn        = btn_q;
    assign btn_valid  = btn_vld_q;
    assign key_err    = err_q;

endmodule
